// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with a sequential load port, PC register and LOAD/RUN/HALTED control
module fetch_stage #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_DATA-1:0] i_branch_target,
  input  logic               i_start,
  input  logic               i_load_enable,
  input  logic [NB_DATA-1:0] i_load_data,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pc_next,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt,
  output logic [NB_ADDR:0]   o_load_count,
  output logic               o_load_full
);
  typedef enum logic [1:0] {LOAD, RUN, HALTED} state_t;
  state_t state, state_next;
  logic [NB_DATA-1:0] pc, pc_nxt, word;
  logic [NB_ADDR:0] ptr;
  logic [NB_DATA-1:0] mem [2**NB_ADDR];
  logic load_we;
  assign word = mem[pc[NB_ADDR+1:2]];
  assign load_we = state == LOAD && i_load_enable && !ptr[NB_ADDR];
  always_comb begin
    state_next = state;
    pc_nxt = pc;
    if (i_valid) begin
      if (state == LOAD && i_start) state_next = RUN;
      else if (state == RUN) begin
        if (i_branch_taken) pc_nxt = i_branch_target;
        else if (!i_stall && word == HALT_WORD) state_next = HALTED;
        else if (!i_stall) pc_nxt = pc + NB_DATA'(4);
      end
    end
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= LOAD;
      pc <= '0;
      ptr <= '0;
    end else begin
      state <= state_next;
      pc <= pc_nxt;
      ptr <= load_we ? ptr + 1'b1 : ptr;
    end
  end
  // Memory is deliberately outside the reset domain so a reset reruns the loaded program
  always_ff @(posedge i_clock) begin
    if (load_we) mem[ptr[NB_ADDR-1:0]] <= i_load_data;
  end
  assign o_instruction = (state == RUN && !i_branch_taken) ? word : '0;
  assign o_pc_next = pc + NB_DATA'(4);
  assign o_pc = pc;
  assign o_halt = state == HALTED;
  assign o_load_count = ptr;
  assign o_load_full = ptr[NB_ADDR];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage (default depth and a 4-word instance for wrap/full)
module tb_fetch_stage;
  logic i_clock = 1'b0, i_reset = 1'b1;
  logic i_valid, i_stall, i_branch_taken, i_start, i_load_enable;
  logic [31:0] i_branch_target, i_load_data;
  logic [31:0] a_instr, a_pc_next, a_pc, b_instr, b_pc_next, b_pc;
  logic a_halt, a_full, b_halt, b_full;
  logic [8:0] a_cnt;
  logic [2:0] b_cnt;
  int checks = 0, errors = 0;

  typedef struct {bit sel; logic [31:0] pc; logic [31:0] instr; logic halt; logic [8:0] cnt; logic full; string name;} exp_t;
  exp_t q[$];

  localparam logic [31:0] W0 = 32'h20010005, W1 = 32'h20020003, W2 = 32'h00221820, H = 32'hFFFFFFFF;
  localparam logic [31:0] X0 = 32'h11111111, X1 = 32'h22222222, X2 = 32'h33333333, X3 = 32'h44444444, X5 = 32'h55555555;

  always #5 i_clock = ~i_clock;

  fetch_stage dut_a (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target), .i_start(i_start),
    .i_load_enable(i_load_enable), .i_load_data(i_load_data), .o_instruction(a_instr),
    .o_pc_next(a_pc_next), .o_pc(a_pc), .o_halt(a_halt), .o_load_count(a_cnt), .o_load_full(a_full)
  );

  fetch_stage #(.NB_ADDR(2)) dut_b (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target), .i_start(i_start),
    .i_load_enable(i_load_enable), .i_load_data(i_load_data), .o_instruction(b_instr),
    .o_pc_next(b_pc_next), .o_pc(b_pc), .o_halt(b_halt), .o_load_count(b_cnt), .o_load_full(b_full)
  );

  exp_t e;
  logic [31:0] m_pc, m_pn, m_ins;
  logic m_h, m_f;
  logic [8:0] m_c;
  always @(negedge i_clock) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      m_pc = e.sel ? b_pc : a_pc;
      m_pn = e.sel ? b_pc_next : a_pc_next;
      m_ins = e.sel ? b_instr : a_instr;
      m_h = e.sel ? b_halt : a_halt;
      m_c = e.sel ? {6'd0, b_cnt} : a_cnt;
      m_f = e.sel ? b_full : a_full;
      checks++;
      if ({m_pc, m_pn, m_ins, m_h, m_c, m_f} !== {e.pc, e.pc + 32'd4, e.instr, e.halt, e.cnt, e.full}) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_next=%h instr=%h halt=%b cnt=%0d full=%b, want pc=%h pc_next=%h instr=%h halt=%b cnt=%0d full=%b",
                 e.name, m_pc, m_pn, m_ins, m_h, m_c, m_f, e.pc, e.pc + 32'd4, e.instr, e.halt, e.cnt, e.full);
      end
    end
  end

  task automatic c(input logic v, s, st, b, input logic [31:0] t, input logic le, input logic [31:0] ld);
    @(posedge i_clock);
    #1;
    i_valid = v; i_start = s; i_stall = st; i_branch_taken = b;
    i_branch_target = t; i_load_enable = le; i_load_data = ld;
  endtask

  task automatic want(input bit sel, input string name, input logic [31:0] pc, instr, input logic halt, input logic [8:0] cnt, input logic full);
    exp_t x;
    x.sel = sel; x.name = name; x.pc = pc; x.instr = instr; x.halt = halt; x.cnt = cnt; x.full = full;
    q.push_back(x);
  endtask

  initial begin
    i_valid = 0; i_start = 0; i_stall = 0; i_branch_taken = 0;
    i_branch_target = 0; i_load_enable = 0; i_load_data = 0;
    c(0, 0, 0, 0, 0, 0, 0); want(0, "reset", 0, 0, 0, 0, 0); want(1, "reset_b", 0, 0, 0, 0, 0);
    i_reset = 0;
    c(0, 1, 0, 0, 0, 1, W0); want(0, "load0", 0, 0, 0, 0, 0);
    c(0, 0, 0, 0, 0, 1, W1); want(0, "start_no_valid", 0, 0, 0, 1, 0);
    c(0, 0, 0, 0, 0, 1, W2); want(0, "load2", 0, 0, 0, 2, 0);
    c(0, 0, 0, 0, 0, 1, H);  want(0, "load3", 0, 0, 0, 3, 0); want(1, "load3_b", 0, 0, 0, 3, 0);
    c(1, 1, 0, 0, 0, 1, 32'h12345678); want(0, "start_with_load", 0, 0, 0, 4, 0); want(1, "b_full", 0, 0, 0, 4, 1);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "run0", 0, W0, 0, 5, 0); want(1, "b_full_ignored", 0, W0, 0, 4, 1);
    c(1, 0, 1, 0, 0, 0, 0); want(0, "stall1", 4, W1, 0, 5, 0);
    c(1, 0, 1, 0, 0, 0, 0); want(0, "stall2", 4, W1, 0, 5, 0);
    c(1, 0, 1, 0, 0, 0, 0); want(0, "stall3", 4, W1, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "stall_release", 4, W1, 0, 5, 0);
    c(1, 0, 0, 1, 0, 0, 0); want(0, "branch_flush", 8, 0, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "branch_target", 0, W0, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "after_branch", 4, W1, 0, 5, 0);
    c(1, 0, 1, 1, 0, 0, 0); want(0, "branch_stall_flush", 8, 0, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "branch_stall_target", 0, W0, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "seq4", 4, W1, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "seq8", 8, W2, 0, 5, 0);
    c(1, 0, 0, 1, 8, 0, 0); want(0, "branch_on_halt", 12, 0, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "branch_on_halt_tgt", 8, W2, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "halt_word", 12, H, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "halted", 12, 0, 1, 5, 0);
    c(1, 1, 0, 1, 0, 1, 32'hABCD0000); want(0, "halted_hold", 12, 0, 1, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "halted_ignores", 12, 0, 1, 5, 0);
    c(0, 0, 0, 0, 0, 0, 0); i_reset = 1; want(0, "reset2", 0, 0, 0, 0, 0);
    c(1, 1, 0, 0, 0, 0, 0); i_reset = 0; want(0, "rerun_load", 0, 0, 0, 0, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "rerun0", 0, W0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      c(0, 0, 0, 0, 0, 0, 0); want(0, "valid_low", 4, W1, 0, 0, 0);
    end
    c(1, 0, 0, 0, 0, 0, 0); want(0, "valid_low_last", 4, W1, 0, 0, 0);
    c(0, 0, 0, 0, 0, 0, 0); want(0, "at8", 8, W2, 0, 0, 0);
    c(0, 0, 0, 0, 0, 0, 0); i_reset = 1; want(0, "async_reset", 0, 0, 0, 0, 0);
    c(1, 1, 0, 0, 0, 0, 0); i_reset = 0; want(0, "rerun_load2", 0, 0, 0, 0, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(0, "rerun_again", 0, W0, 0, 0, 0);
    c(0, 0, 0, 0, 0, 0, 0); i_reset = 1; want(1, "reset3_b", 0, 0, 0, 0, 0);
    c(0, 0, 0, 0, 0, 1, X0); i_reset = 0; want(1, "b_load0", 0, 0, 0, 0, 0);
    c(0, 0, 0, 0, 0, 1, X1); want(1, "b_load1", 0, 0, 0, 1, 0);
    c(0, 0, 0, 0, 0, 1, X2); want(1, "b_load2", 0, 0, 0, 2, 0);
    c(0, 0, 0, 0, 0, 1, X3); want(1, "b_load3", 0, 0, 0, 3, 0);
    c(0, 0, 0, 0, 0, 1, X5); want(1, "b_load4_full", 0, 0, 0, 4, 1);
    c(1, 1, 0, 0, 0, 0, 0); want(1, "b_fifth_ignored", 0, 0, 0, 4, 1); want(0, "a_five_loads", 0, 0, 0, 5, 0);
    c(1, 0, 0, 0, 0, 0, 0); want(1, "b_run0", 0, X0, 0, 4, 1);
    c(1, 0, 0, 0, 0, 0, 0); want(1, "b_run4", 4, X1, 0, 4, 1);
    c(1, 0, 0, 0, 0, 0, 0); want(1, "b_run8", 8, X2, 0, 4, 1);
    c(1, 0, 0, 0, 0, 0, 0); want(1, "b_run12", 12, X3, 0, 4, 1);
    c(0, 0, 0, 0, 0, 0, 0); want(1, "b_wrap16", 16, X0, 0, 4, 1);
    c(0, 0, 0, 0, 0, 0, 0);
    c(0, 0, 0, 0, 0, 0, 0);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline, directly upstream of the decode stage. It owns the program counter and a word-addressed instruction memory filled through a sequential load port. It presents the current instruction and PC+4 to decode, and handles stalls, branch/jump redirects and HALT detection through a three-state controller (LOAD, RUN, HALTED).

## Interface
- NB_DATA, 32: data, instruction and PC width.
- NB_ADDR, 8: instruction-memory word-address width; depth = 2^NB_ADDR words.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts fetch.

- i_clock  in  1  single clock; all state updates on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  global step enable; PC and controller advance only when high.
- i_stall  in  1  hazard stall from decode/hazard unit; holds PC.
- i_branch_taken  in  1  redirect request from a later stage.
- i_branch_target  in  NB_DATA  redirect byte address.
- i_start  in  1  LOAD -> RUN request.
- i_load_enable  in  1  write i_load_data at the load pointer.
- i_load_data  in  NB_DATA  instruction word to load.
- o_instruction  out  NB_DATA  instruction to decode (combinational).
- o_pc_next  out  NB_DATA  PC+4 of the presented instruction (combinational).
- o_pc  out  NB_DATA  current PC.
- o_halt  out  1  high in HALTED.
- o_load_count  out  NB_ADDR+1  number of words loaded.
- o_load_full  out  1  memory full; further loads ignored.

## Operation
- Reset (async) sets: PC=0, state=LOAD, load pointer=0. Resulting outputs: o_pc=0, o_pc_next=4, o_instruction=0, o_halt=0, o_load_count=0, o_load_full=0. Memory contents are not cleared.
- Memory read is combinational at word index PC[NB_ADDR+1:2]. PC[1:0] are ignored. Upper PC bits are ignored, so the index wraps modulo depth.

LOAD state:
- o_instruction=0 (NOP). PC is held at 0.
- On posedge with i_load_enable and !o_load_full: mem[ptr] <= i_load_data, ptr++.
- o_load_full = (ptr == 2^NB_ADDR).
- i_load_enable is not gated by i_valid.
- i_start (sampled with i_valid) moves to RUN. If i_start and i_load_enable are asserted in the same cycle, the write completes and the state moves to RUN.

RUN state:
- o_instruction = mem[PC], except it is forced to 0 when i_branch_taken is high (flushes the wrong-path slot).
- Advance condition (i_valid high), in priority order:
  1. i_branch_taken: PC <= i_branch_target. Applies even when i_stall is high. HALT is not detected this cycle.
  2. else i_stall: PC held, instruction re-presented unchanged.
  3. else if mem[PC] == HALT_WORD: PC held, state <= HALTED. The HALT word is presented to decode for exactly this one advancing cycle.
  4. else PC <= PC + 4. Addition wraps modulo 2^NB_DATA.
- i_valid low: nothing changes. Outputs still reflect the current PC.
- Loads are ignored in RUN and HALTED.

HALTED state:
- o_halt=1, o_instruction=0, PC frozen. All inputs are ignored.
- Exit only via i_reset. Reset reloads nothing; memory is retained, so reset followed by i_start reruns the program.

## Timing
- Zero-cycle latency from PC to o_instruction/o_pc_next. Decode registers these on its own posedge with its i_valid.
- A PC change is visible on o_pc the cycle after the advancing posedge.
- A branch redirect costs one NOP bubble (the flushed cycle). The target instruction appears the next cycle.
- o_halt rises the cycle after the HALT word's advancing posedge.
- o_load_count/o_load_full update one posedge after each accepted write.
- Reset asserted mid-operation clears PC, state and pointer immediately (asynchronous), with no dependence on the clock. Deassertion is synchronous in effect: the first posedge after deassertion acts in LOAD.

## Test plan
- Load 4 words (0x20010005, 0x20020003, 0x00221820, 0xFFFFFFFF), then i_start, i_valid=1 always -> o_pc runs 0,4,8,12. o_instruction shows each word in order. o_halt=1 the cycle after PC=12. o_pc stays 12 and o_instruction=0 thereafter.
- Stall: assert i_stall for 3 cycles at PC=4 -> o_pc=4 and o_instruction=0x20020003 for all 3 cycles. PC=8 the cycle after release.
- Branch: at PC=8 assert i_branch_taken with target 0x0 -> o_instruction=0 that cycle and o_pc=0 next. The same is required with i_stall=1 simultaneously. A branch while the HALT word is presented must leave o_halt=0.
- Full memory, NB_ADDR=2: 5 load writes -> o_load_count=4, o_load_full=1. The 5th write is ignored (mem[0] unchanged). In RUN, PC=16 wraps to read mem[0].
- i_valid gating: i_valid=0 for 5 cycles in RUN -> o_pc constant. i_start with i_valid=0 -> stays in LOAD.
- Async reset mid-RUN at PC=8, asserted between edges -> o_pc=0, o_instruction=0, o_load_count=0 before the next posedge. Memory is retained; i_start reruns from 0x20010005.
